ksa32_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 32-bit Kogge-Stone adder among NREQ requesters. It accepts one add request at a time through a per-requester valid/ready handshake and drives registered operands into the adder. It captures sum, carry-out and overflow one cycle later and presents them on a single response channel tagged with the requester id. It sits between client blocks and the adder instance, which it drives through the add_* ports.

---
 rtl/ksa32_share_arb.sv | 127 ++++++++++++
 tb/tb_ksa32_share_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa32_share_arb.sv
// rtl/ksa32_share_arb.sv - round-robin sequencer sharing one external 32-bit adder among NREQ requesters
module ksa32_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_sum,
    input  logic                 add_cout,
    input  logic                 add_ovf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic [IDW-1:0]       rsp_id
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id_q;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [IDW:0]    w_idx;
    logic            w_found;
    logic            w_any;
    logic            w_grant;
    logic [31:0]     r_add_a;
    logic [31:0]     r_add_b;
    logic [31:0]     r_rsp_sum;
    logic            r_rsp_cout;
    logic            r_rsp_ovf;
    logic [IDW-1:0]  r_rsp_id;

    // First valid requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    assign w_any     = |req_valid;
    assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;
    // Gated by rst_n so no grant is shown while reset is held
    assign w_grant   = rst_n && w_any &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = w_grant ? S_EXEC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready = NREQ'(1) << w_win;
        end
        rsp_valid = (r_state == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_id_q     <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_ovf  <= 1'b0;
            r_rsp_id   <= '0;
        end else begin
            if (w_grant) begin
                r_add_a <= req_a[{w_win, 5'b0} +: 32];
                r_add_b <= req_b[{w_win, 5'b0} +: 32];
                r_id_q  <= w_win;
                r_ptr   <= w_ptr_nxt;
            end
            // Adder output has a full cycle from the operand registers
            if (r_state == S_EXEC) begin
                r_rsp_sum  <= add_sum;
                r_rsp_cout <= add_cout;
                r_rsp_ovf  <= add_ovf;
                r_rsp_id   <= r_id_q;
            end
        end
    end

    assign add_a    = r_add_a;
    assign add_b    = r_add_b;
    assign rsp_sum  = r_rsp_sum;
    assign rsp_cout = r_rsp_cout;
    assign rsp_ovf  = r_rsp_ovf;
    assign rsp_id   = r_rsp_id;

endmodule

// File: tb/tb_ksa32_share_arb.sv
// tb/tb_ksa32_share_arb.sv - randomized and directed checks of ksa32_share_arb against a transaction-level model
module tb_ksa32_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         add_a;
    logic [31:0]         add_b;
    logic [31:0]         add_sum;
    logic                add_cout;
    logic                add_ovf;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_sum;
    logic                rsp_cout;
    logic                rsp_ovf;
    logic [IDW-1:0]      rsp_id;

    always #5 clk = ~clk;

    ksa32_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .add_ovf   (add_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id)
    );

    // Stand-in for the shared adder instance
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
    assign add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model: one in-flight operation, one pending response
    int          m_ptr;
    int          m_last_g;
    int          m_iid;
    int          m_id;
    bit          m_infl;
    bit          m_resp;
    bit          m_cout;
    bit          m_ovf;
    logic [31:0] m_ia, m_ib, m_sum, m_add_a, m_add_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_infl = 0; m_resp = 0; m_iid = 0; m_id = 0;
        m_sum = '0; m_cout = 0; m_ovf = 0; m_add_a = '0; m_add_b = '0;
        m_ia = '0; m_ib = '0;
    endtask

    task automatic tick();
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        m_last_g = -1;
        if (!rst_n) begin
            model_reset();
        end else if (!m_infl && (!m_resp || rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (m_last_g < 0 && req_valid[i]) m_last_g = i;
            end
        end
        exp_rdy = '0;
        if (m_last_g >= 0) exp_rdy[m_last_g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, m_resp);
        check("rsp_sum",   rsp_sum,   m_sum);
        check("rsp_cout",  rsp_cout,  m_cout);
        check("rsp_ovf",   rsp_ovf,   m_ovf);
        check("rsp_id",    rsp_id,    m_id);
        check("add_a",     add_a,     m_add_a);
        check("add_b",     add_b,     m_add_b);
    endtask

    task automatic adv();
        longint s;
        @(posedge clk);
        if (rst_n) begin
            if (m_infl) begin
                s      = longint'(m_ia) + longint'(m_ib);
                m_sum  = s[31:0];
                m_cout = ((s >> 32) != 0);
                s      = longint'($signed(m_ia)) + longint'($signed(m_ib));
                m_ovf  = (s > SMAX) || (s < SMIN);
                m_id   = m_iid;
                m_resp = 1;
                m_infl = 0;
            end else if (m_resp && rsp_ready) begin
                m_resp = 0;
            end
            if (m_last_g >= 0) begin
                m_infl  = 1;
                m_ia    = req_a[32*m_last_g +: 32];
                m_ib    = req_b[32*m_last_g +: 32];
                m_iid   = m_last_g;
                m_ptr   = (m_last_g + 1) % NREQ;
                m_add_a = m_ia;
                m_add_b = m_ib;
            end
        end
        #1;
    endtask

    task automatic cyc();
        tick();
        adv();
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]     = 1'b1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) cyc();
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int grants[$];
        int gcyc[$];
        logic [31:0] saved;

        rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        model_reset();
        m_last_g = -1;
        repeat (3) cyc();
        req_valid = '0;
        rst_n = 1'b1;

        // Carry-out through requester 0
        drain();
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0001);
        tick(); check("co_grant", req_ready, 4'b0001); adv();
        req_valid[0] = 1'b0;
        tick(); check("co_exec_valid", rsp_valid, 1'b0); adv();
        tick();
        check("co_valid", rsp_valid, 1'b1);
        check("co_sum", rsp_sum, 32'h0000_0000);
        check("co_cout", rsp_cout, 1'b1);
        check("co_ovf", rsp_ovf, 1'b0);
        check("co_id", rsp_id, 2'd0);
        adv();

        // Signed overflow through requester 2
        drain();
        set_req(2, 32'h7FFF_FFFF, 32'h0000_0001);
        tick(); check("ov_grant", req_ready, 4'b0100); adv();
        req_valid[2] = 1'b0;
        cyc();
        tick();
        check("ov_sum", rsp_sum, 32'h8000_0000);
        check("ov_cout", rsp_cout, 1'b0);
        check("ov_ovf", rsp_ovf, 1'b1);
        check("ov_id", rsp_id, 2'd2);
        adv();

        // Backpressure with requester 1 waiting
        drain();
        rsp_ready = 1'b0;
        set_req(1, rand_op(), rand_op());
        cyc();
        set_req(1, rand_op(), rand_op());
        cyc();
        tick(); saved = m_sum; adv();
        repeat (5) begin
            tick();
            check("bp_rdy", req_ready, 4'b0000);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_hold", rsp_sum, saved);
            adv();
        end
        rsp_ready = 1'b1;
        tick(); check("bp_grant", req_ready, 4'b0010); adv();
        req_valid = '0;
        tick(); check("bp_exec", rsp_valid, 1'b0); adv();
        tick(); check("bp_next", rsp_valid, 1'b1); adv();

        // Single request, then idle: operands must persist
        drain();
        rsp_ready = 1'b0;
        set_req(3, 32'h1234_5678, 32'h1111_1111);
        cyc();
        req_valid = '0;
        cyc();
        tick(); check("ih_sum", rsp_sum, 32'h2345_6789); adv();
        rsp_ready = 1'b1;
        cyc();
        repeat (3) begin
            tick();
            check("ih_add_a", add_a, 32'h1234_5678);
            check("ih_add_b", add_b, 32'h1111_1111);
            check("ih_valid", rsp_valid, 1'b0);
            adv();
        end
        set_req(0, 32'h5, 32'h6);
        tick(); check("ih_regrant", req_ready, 4'b0001); adv();
        req_valid = '0;

        // Reset during EXEC, then round-robin from pointer 0
        drain();
        for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op());
        cyc();
        rst_n = 1'b0;
        tick();
        check("rm_valid", rsp_valid, 1'b0);
        check("rm_add_a", add_a, 32'h0);
        check("rm_sum", rsp_sum, 32'h0);
        check("rm_rdy", req_ready, 4'b0000);
        adv();
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grants.push_back(i);
                    gcyc.push_back(c);
                end
            end
            g = m_last_g;
            adv();
            if (g >= 0) set_req(g, rand_op(), rand_op());
        end
        check("rr_count", 64'(grants.size() >= 6), 64'd1);
        for (int k = 0; k < 6 && k < grants.size(); k++)
            check("rr_order", 64'(grants[k]), 64'(k % NREQ));
        for (int k = 0; k < 5 && k + 1 < gcyc.size(); k++)
            check("rr_gap", 64'(gcyc[k+1] - gcyc[k]), 64'd2);

        // Randomized traffic with backpressure and withdrawals
        drain();
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, rand_op(), rand_op());
                else if (req_valid[i] && $urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
            end
            tick();
            g = m_last_g;
            adv();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
